// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants and register-use decode helpers
// used by the issue-stage hazard logic.
package core_pkg;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_PIM    = 7'b0001011;

    // Results of these ops return through the memory/PIM completion path.
    function automatic logic is_long_op(input logic [6:0] opcode);
        return (opcode == OPCODE_LOAD) || (opcode == OPCODE_PIM);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OPCODE_JAL) || (opcode == OPCODE_LUI) ||
                 (opcode == OPCODE_AUIPC));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPCODE_R) || (opcode == OPCODE_STORE) ||
               (opcode == OPCODE_BRANCH) || (opcode == OPCODE_PIM);
    endfunction

    function automatic logic writes_rd(input logic [6:0] opcode);
        return !((opcode == OPCODE_STORE) || (opcode == OPCODE_BRANCH));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with increment enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Issue-stage scoreboard for long-latency producers: tracks pending destination
// registers, stalls on RAW/WAW/capacity hazards and flags bad completions.
module wb_scoreboard
    import core_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             issue_valid_i,
    input  logic [6:0]       issue_opcode_i,
    input  logic [4:0]       issue_rs1_i,
    input  logic [4:0]       issue_rs2_i,
    input  logic [4:0]       issue_rd_i,
    input  logic             flush_i,
    input  logic             cmpl_valid_i,
    input  logic [4:0]       cmpl_rd_i,
    output logic             stall_o,
    output logic [31:0]      pending_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic [31:0]      stall_cnt_o,
    output logic             err_o
);

    logic [31:0]      pending_r;
    logic [CNT_W-1:0] outstanding_r;
    logic             err_r;

    logic             clr_rs1_s;
    logic             clr_rs2_s;
    logic             clr_rd_s;
    logic             raw_s;
    logic             waw_s;
    logic             cap_s;
    logic             stall_s;
    logic             fire_long_s;
    logic             cmpl_ok_s;
    logic             cmpl_err_s;
    logic [31:0]      set_mask_s;
    logic [31:0]      clr_mask_s;
    logic [31:0]      pending_next_s;
    logic [CNT_W-1:0] outstanding_next_s;

    // Hazard detection; a same-cycle completion is covered by WB forwarding.
    always_comb begin
        clr_rs1_s = cmpl_valid_i && (cmpl_rd_i == issue_rs1_i) && (issue_rs1_i != 5'd0);
        clr_rs2_s = cmpl_valid_i && (cmpl_rd_i == issue_rs2_i) && (issue_rs2_i != 5'd0);
        clr_rd_s  = cmpl_valid_i && (cmpl_rd_i == issue_rd_i)  && (issue_rd_i  != 5'd0);

        raw_s = (uses_rs1(issue_opcode_i) && pending_r[issue_rs1_i] && !clr_rs1_s) ||
                (uses_rs2(issue_opcode_i) && pending_r[issue_rs2_i] && !clr_rs2_s);
        waw_s = writes_rd(issue_opcode_i) && (issue_rd_i != 5'd0) &&
                pending_r[issue_rd_i] && !clr_rd_s;
        cap_s = is_long_op(issue_opcode_i) &&
                (outstanding_r == CNT_W'(MAX_OUTSTANDING)) && !cmpl_valid_i;

        stall_s     = rst_ni && issue_valid_i && !flush_i && (raw_s || waw_s || cap_s);
        fire_long_s = rst_ni && issue_valid_i && !flush_i && !stall_s &&
                      is_long_op(issue_opcode_i);
    end

    // Next tracking state; an illegal completion changes nothing but the error flag.
    always_comb begin
        cmpl_ok_s  = cmpl_valid_i && (outstanding_r != CNT_W'(0)) &&
                     ((cmpl_rd_i == 5'd0) || pending_r[cmpl_rd_i]);
        cmpl_err_s = cmpl_valid_i && !cmpl_ok_s;

        clr_mask_s = cmpl_ok_s ? (32'd1 << cmpl_rd_i) : 32'd0;
        set_mask_s = (fire_long_s && (issue_rd_i != 5'd0)) ? (32'd1 << issue_rd_i) : 32'd0;
        // Clear before set so a same-register completion and re-issue leaves the bit set.
        pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

        case ({fire_long_s, cmpl_ok_s})
            2'b10:   outstanding_next_s = outstanding_r + CNT_W'(1);
            2'b01:   outstanding_next_s = outstanding_r - CNT_W'(1);
            default: outstanding_next_s = outstanding_r;
        endcase
    end

    // Tracking registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_r     <= 32'd0;
            outstanding_r <= '0;
            err_r         <= 1'b0;
        end else begin
            pending_r     <= pending_next_s;
            outstanding_r <= outstanding_next_s;
            err_r         <= err_r | cmpl_err_s;
        end
    end

    sat_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (stall_s),
        .count (stall_cnt_o)
    );

    assign stall_o       = stall_s;
    assign pending_o     = pending_r;
    assign outstanding_o = outstanding_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios followed by random
// traffic, all checked against a register-level reference model.
module tb_wb_scoreboard;

    localparam int MAXO = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_PIM    = 7'b0001011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [6:0]  issue_opcode;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        cmpl_valid;
    logic [4:0]  cmpl_rd;
    logic        stall;
    logic [31:0] pending;
    logic [2:0]  outstanding;
    logic [31:0] stall_cnt;
    logic        err;

    always #5 clk = ~clk;

    wb_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .issue_valid_i  (issue_valid),
        .issue_opcode_i (issue_opcode),
        .issue_rs1_i    (issue_rs1),
        .issue_rs2_i    (issue_rs2),
        .issue_rd_i     (issue_rd),
        .flush_i        (flush),
        .cmpl_valid_i   (cmpl_valid),
        .cmpl_rd_i      (cmpl_rd),
        .stall_o        (stall),
        .pending_o      (pending),
        .outstanding_o  (outstanding),
        .stall_cnt_o    (stall_cnt),
        .err_o          (err)
    );

    int tests_run = 0;
    int failed    = 0;

    // Reference model: one flag per architectural register plus a list of
    // destinations whose responses are still due.
    bit          m_pend [32];
    int          m_out;
    bit          m_err;
    int unsigned m_scnt;
    int          inflight [$];

    function automatic bit f_rs1(logic [6:0] op);
        return !(op == OP_JAL || op == OP_LUI || op == OP_AUIPC);
    endfunction
    function automatic bit f_rs2(logic [6:0] op);
        return op == OP_R || op == OP_STORE || op == OP_BRANCH || op == OP_PIM;
    endfunction
    function automatic bit f_rd(logic [6:0] op);
        return !(op == OP_STORE || op == OP_BRANCH);
    endfunction
    function automatic bit f_long(logic [6:0] op);
        return op == OP_LOAD || op == OP_PIM;
    endfunction
    function automatic bit f_clr(bit cv, logic [4:0] crd, logic [4:0] r);
        return cv && crd == r && r != 5'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_out  = 0;
        m_err  = 1'b0;
        m_scnt = 0;
        inflight.delete();
    endtask

    // One clock cycle: drive inputs, check stall mid-cycle, advance, check state.
    task automatic step(input bit rst, input bit v, input logic [6:0] op,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input bit fl, input bit cv, input logic [4:0] crd);
        bit raw, waw, cap, exp_stall, fire, dec;
        logic [31:0] exp_pend;
        rst_n = rst; issue_valid = v; issue_opcode = op;
        issue_rs1 = a; issue_rs2 = b; issue_rd = d;
        flush = fl; cmpl_valid = cv; cmpl_rd = crd;
        #4;
        raw = (f_rs1(op) && m_pend[a] && !f_clr(cv, crd, a)) ||
              (f_rs2(op) && m_pend[b] && !f_clr(cv, crd, b));
        waw = f_rd(op) && d != 5'd0 && m_pend[d] && !f_clr(cv, crd, d);
        cap = f_long(op) && m_out == MAXO && !cv;
        exp_stall = rst && v && !fl && (raw || waw || cap);
        check("stall", {31'd0, stall}, {31'd0, exp_stall});
        fire = rst && v && !fl && !exp_stall;
        if (!rst) begin
            model_reset();
        end else begin
            dec = 1'b0;
            if (cv) begin
                if (m_out == 0 || (crd != 5'd0 && !m_pend[crd])) begin
                    m_err = 1'b1;
                end else begin
                    m_pend[crd] = 1'b0;
                    dec = 1'b1;
                    foreach (inflight[i]) begin
                        if (inflight[i] == int'(crd)) begin
                            inflight.delete(i);
                            break;
                        end
                    end
                end
            end
            if (exp_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
            if (fire && f_long(op)) begin
                if (d != 5'd0) m_pend[d] = 1'b1;
                inflight.push_back(int'(d));
                m_out++;
            end
            if (dec) m_out--;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) exp_pend[i] = m_pend[i];
        check("pending", pending, exp_pend);
        check("outstanding", {29'd0, outstanding}, m_out);
        check("err", {31'd0, err}, {31'd0, m_err});
        check("stall_cnt", stall_cnt, m_scnt);
    endtask

    task automatic idle(input bit cv, input logic [4:0] crd);
        step(1'b1, 1'b0, OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0, cv, crd);
    endtask

    logic [6:0] ops [9];
    logic [6:0] r_op;
    logic [4:0] r_a, r_b, r_d, r_crd;
    bit         r_v, r_fl, r_cv;
    int         idx;
    logic [31:0] scnt_before;

    initial begin
        ops = '{OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_PIM, OP_IMM};
        model_reset();
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, OP_LOAD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 5'd3);
        step(1'b0, 1'b0, OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);

        // Load-use: consumer stalls until completion, issues in completion cycle.
        step(1'b1, 1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, OP_R, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b1, OP_R, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1, 5'd5);
        check("load_use_pend5", {31'd0, pending[5]}, 32'd0);

        // Load to x0 still counts an outstanding response.
        step(1'b1, 1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        check("x0_outstanding", {29'd0, outstanding}, 32'd1);
        idle(1'b1, 5'd0);

        // Capacity: fifth load stalls, then fires alongside a completion.
        for (int i = 1; i <= 4; i++)
            step(1'b1, 1'b1, OP_LOAD, 5'd0, 5'd0, 5'(i), 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b1, OP_LOAD, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b1, OP_LOAD, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1, 5'd1);
        check("cap_outstanding", {29'd0, outstanding}, 32'd4);
        idle(1'b1, 5'd2); idle(1'b1, 5'd3); idle(1'b1, 5'd4); idle(1'b1, 5'd6);

        // WAW on LUI, then a store with clear sources.
        step(1'b1, 1'b1, OP_LOAD, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b1, OP_LUI, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b1, OP_STORE, 5'd1, 5'd8, 5'd7, 1'b0, 1'b0, 5'd0);
        // Same-register completion and re-issue leaves the bit set.
        step(1'b1, 1'b1, OP_PIM, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7);
        idle(1'b1, 5'd7);

        // Flush hides the hazard without touching state.
        step(1'b1, 1'b1, OP_LOAD, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 5'd0);
        scnt_before = stall_cnt;
        step(1'b1, 1'b1, OP_R, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 5'd0);
        check("flush_cnt", stall_cnt, scnt_before);
        idle(1'b1, 5'd9);

        // Protocol errors: empty completion, then sticky, then cleared by reset.
        idle(1'b1, 5'd4);
        idle(1'b0, 5'd0);
        idle(1'b0, 5'd0);
        check("err_sticky", {31'd0, err}, 32'd1);
        step(1'b1, 1'b1, OP_LOAD, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0);
        idle(1'b1, 5'd5);
        step(1'b0, 1'b1, OP_R, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 5'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // Reset mid-operation: the late completion is now illegal.
        step(1'b1, 1'b1, OP_LOAD, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        idle(1'b1, 5'd3);
        step(1'b0, 1'b0, OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            r_op = ops[$urandom_range(0, 8)];
            r_a  = 5'($urandom_range(0, 7));
            r_b  = 5'($urandom_range(0, 7));
            r_d  = 5'($urandom_range(0, 7));
            r_v  = ($urandom_range(0, 9) < 8);
            r_fl = ($urandom_range(0, 9) == 0);
            r_cv = 1'b0;
            r_crd = 5'($urandom_range(0, 31));
            if (inflight.size() > 0 && $urandom_range(0, 9) < 4) begin
                idx   = $urandom_range(0, inflight.size() - 1);
                r_cv  = 1'b1;
                r_crd = 5'(inflight[idx]);
            end
            step(1'b1, r_v, r_op, r_a, r_b, r_d, r_fl, r_cv, r_crd);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Register-hazard scoreboard at the decode/issue stage of the RISC-V pipeline. It handles what WB-stage forwarding cannot: results from long-latency producers (loads, PIM ops) that have not yet returned. It tracks every destination register with a pending long-latency write and stalls issue on RAW, WAW or outstanding-capacity hazards. It releases an entry when the memory/PIM return path reports completion. It also keeps a stall-cycle counter and a sticky protocol-error flag.

## Interface
Parameters:
- MAX_OUTSTANDING, 4, maximum in-flight long-latency ops (1..15)
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding-counter width (derived; not overridden)

Ports (clock `clk_i`, reset `rst_ni`; one clock, synchronous active-low reset):
- clk_i  input  1  core clock
- rst_ni  input  1  synchronous active-low reset
- issue_valid_i  input  1  decode holds a valid instruction
- issue_opcode_i  input  7  instruction opcode
- issue_rs1_i  input  5  source register 1
- issue_rs2_i  input  5  source register 2
- issue_rd_i  input  5  destination register
- flush_i  input  1  squash decode instruction this cycle
- cmpl_valid_i  input  1  a long-latency result is written back this cycle
- cmpl_rd_i  input  5  destination of the completing result
- stall_o  output  1  hold fetch/decode, insert bubble into EX
- pending_o  output  32  pending-write bit per register (bit 0 constant 0)
- outstanding_o  output  CNT_W  in-flight long-latency op count
- stall_cnt_o  output  32  saturating count of stall cycles
- err_o  output  1  sticky completion-protocol error

## Operation
- Register-use decode:
  - rs1 is used unless opcode is JAL, LUI or AUIPC.
  - rs2 is used for R, STORE, BRANCH, PIM.
  - rd is written unless opcode is STORE or BRANCH.
  - The op is long-latency if opcode is LOAD or PIM.
- Same-cycle completion bypass: `clr(r)` = cmpl_valid_i && cmpl_rd_i==r && r!=0. The completing value is covered by WB forwarding.
- RAW hazard: a used rs with pending[rs] && !clr(rs).
- WAW hazard: rd written, rd!=0, pending[rd] && !clr(rd).
- Capacity hazard: long-latency op && outstanding_o==MAX_OUTSTANDING && !cmpl_valid_i.
- stall_o = issue_valid_i && !flush_i && (RAW || WAW || capacity). It is combinational from registered state and current inputs.
- fire = issue_valid_i && !flush_i && !stall_o.
- On fire of a long-latency op:
  - Set pending[rd] if rd!=0.
  - Increment outstanding in every case, including rd=x0, because the response still returns.
- On cmpl_valid_i:
  - Clear pending[cmpl_rd_i].
  - Decrement outstanding.
- Simultaneous fire (long) and completion:
  - Counter is unchanged.
  - Same rd: clear-then-set, so the bit ends at 1.
- Protocol error: cmpl_valid_i when outstanding_o==0, or with cmpl_rd_i!=0 and pending clear.
  - Sets err_o, which holds until reset.
  - No counter decrement.
  - No other state change.
- stall_cnt_o increments each cycle stall_o=1 and saturates at 32'hFFFF_FFFF.
- flush_i blocks both the issue and the stall. It never clears pending state, because in-flight ops still complete.

## Timing
- Reset (rst_ni=0 at posedge): pending_o=0, outstanding_o=0, stall_cnt_o=0, err_o=0.
  - stall_o is 0 during reset regardless of inputs.
  - Reset mid-operation discards all tracking; completions arriving later flag err_o.
- Pending/counter update at the posedge after fire or completion. A dependent instruction presented the next cycle sees the new state.
- Load-use latency: a consumer issues in the cycle its producer's completion arrives, with zero extra bubble.
- stall_o has zero-cycle latency from inputs. No registered stall path.

## Structure
- Shared package `core_pkg` holds:
  - the OPCODE_* constants (R, LOAD, STORE, BRANCH, JAL, LUI, AUIPC, PIM), which replace per-file defines;
  - an `is_long_op()` function;
  - `uses_rs1()`, `uses_rs2()`, `writes_rd()` functions.
- One natural sub-module: `sat_counter` (parameterised width, inc enable, saturate), instantiated for stall_cnt_o.

## Test plan
- Reset, then LOAD rd=x5 fires, then ADD rs1=x5 the next cycle → stall_o=1 until cmpl_valid_i with cmpl_rd_i=5. In that completion cycle stall_o=0, and afterwards pending_o[5]=0, outstanding_o=0.
- LOAD rd=x0 fires → pending_o=0, outstanding_o=1. cmpl_rd_i=0 → outstanding_o=0, err_o=0.
- MAX_OUTSTANDING=4: four LOADs to x1..x4 fire, then a fifth LOAD to x6 → stall_o=1. A completion the same cycle → fire, outstanding_o stays 4.
- LOAD x7 pending, then LUI rd=x7 → stall_o=1 (WAW). Then STORE rs2=x8 with x8 clear → stall_o=0.
- cmpl_valid_i with outstanding_o=0 → err_o=1 and stays 1, counters unchanged. rst_ni=0 → err_o=0.
- Hazarding instruction with flush_i=1 → stall_o=0, stall_cnt_o unchanged, pending_o unchanged.
